// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared constants and decode types for the data-side MMIO bridge
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    // Word offsets inside the MMIO window (addr[1:0] is ignored by decode)
    localparam logic [3:0] OFF_GPIO   = 4'h0;
    localparam logic [3:0] OFF_CYCLE  = 4'h4;
    localparam logic [3:0] OFF_TXDATA = 4'h8;
    localparam logic [3:0] OFF_TXSTAT = 4'hC;

    // TXSTAT field positions
    localparam int TXSTAT_FULL    = 0;
    localparam int TXSTAT_EMPTY   = 1;
    localparam int TXSTAT_OVF     = 2;
    localparam int TXSTAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_MMIO,
        SEL_NONE
    } sel_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with count, accepts push when full if a pop coincides
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    // A full FIFO can still take a byte when the head leaves at the same edge
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; reset discards any pending entries
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, not reset
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// rtl/dmem_mmio_bridge.sv - single-cycle data memory plus GPIO, cycle counter and TX FIFO window
module dmem_mmio_bridge #(
    parameter int          RAM_WORDS  = 256,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = mmio_pkg::MMIO_BASE
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dmem_wren,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_dmem_data_in,
    output logic [31:0] o_dmem_data_out,
    output logic [31:0] o_gpio_out,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
);

    import mmio_pkg::*;

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]       r_ram [RAM_WORDS];
    logic [31:0]       r_gpio;
    logic [31:0]       r_cycle;
    logic              r_ovf;

    sel_e              w_sel;
    logic [3:0]        w_off;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr_ram;
    logic              w_wr_gpio;
    logic              w_wr_cycle;
    logic              w_wr_txdata;
    logic              w_wr_txstat;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [31:0]       w_txstat;
    logic [31:0]       w_rdata;
    logic              w_unused_addr;

    // Upper RAM address bits alias, byte-lane bits are ignored
    assign w_unused_addr = ^{i_alu_result[30:RAM_AW+2], i_alu_result[1:0]};

    // Address decode: bit 31 splits RAM from the MMIO window
    always_comb begin
        w_sel     = (i_alu_result[31] == MMIO_BASE[31]) ? SEL_MMIO : SEL_RAM;
        w_off     = {i_alu_result[3:2], 2'b00};
        w_ram_idx = i_alu_result[RAM_AW+1:2];
    end

    assign w_wr_ram    = i_dmem_wren && (w_sel == SEL_RAM);
    assign w_wr_gpio   = i_dmem_wren && (w_sel == SEL_MMIO) && (w_off == OFF_GPIO);
    assign w_wr_cycle  = i_dmem_wren && (w_sel == SEL_MMIO) && (w_off == OFF_CYCLE);
    assign w_wr_txdata = i_dmem_wren && (w_sel == SEL_MMIO) && (w_off == OFF_TXDATA);
    assign w_wr_txstat = i_dmem_wren && (w_sel == SEL_MMIO) && (w_off == OFF_TXSTAT);

    assign o_tx_valid = !w_empty;
    assign w_pop      = o_tx_valid && i_tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_wr_txdata),
        .i_pop   (w_pop),
        .i_wdata (i_dmem_data_in[7:0]),
        .o_rdata (o_tx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Word RAM write port, contents are not reset
    always_ff @(posedge i_clk) begin
        if (w_wr_ram) r_ram[w_ram_idx] <= i_dmem_data_in;
    end

    // GPIO, free-running cycle counter and sticky overflow flag
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gpio  <= '0;
            r_cycle <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr_gpio) r_gpio <= i_dmem_data_in;
            r_cycle <= w_wr_cycle ? i_dmem_data_in : (r_cycle + 32'd1);
            if (w_wr_txdata && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr_txstat && i_dmem_data_in[TXSTAT_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // TXSTAT assembly from live FIFO state
    always_comb begin
        w_txstat                          = '0;
        w_txstat[TXSTAT_FULL]             = w_full;
        w_txstat[TXSTAT_EMPTY]            = w_empty;
        w_txstat[TXSTAT_OVF]              = r_ovf;
        w_txstat[TXSTAT_CNT_LSB +: 8]     = 8'(w_count);
    end

    // Zero-latency read mux; TXDATA reads as 0 and never pops
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            SEL_RAM: w_rdata = r_ram[w_ram_idx];
            SEL_MMIO: begin
                case (w_off)
                    OFF_GPIO:   w_rdata = r_gpio;
                    OFF_CYCLE:  w_rdata = r_cycle;
                    OFF_TXSTAT: w_rdata = w_txstat;
                    default:    w_rdata = '0;
                endcase
            end
            default: w_rdata = '0;
        endcase
    end

    assign o_dmem_data_out = w_rdata;
    assign o_gpio_out      = r_gpio;

endmodule
